// File: rtl/alu_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_sched_if                                           |
// | Description : Request/response and ALU-side signal bundle for the    |
// |               shared-ALU scheduler.                                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface alu_sched_if #(
  parameter int WIDTH = 16
);
  // requester 0
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             rsp0_valid;
  logic [WIDTH-1:0] rsp0_z;
  logic             rsp0_carry;
  // requester 1
  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp1_valid;
  logic [WIDTH-1:0] rsp1_z;
  logic             rsp1_carry;
  // status and shared ALU
  logic             busy;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_c;
  logic             alu_cin;
  logic [WIDTH-1:0] alu_z;
  logic             alu_cout;

  // scheduler side
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_z, alu_cout,
    output req0_ready, rsp0_valid, rsp0_z, rsp0_carry,
    output req1_ready, rsp1_valid, rsp1_z, rsp1_carry,
    output busy, alu_a, alu_b, alu_c, alu_cin
  );

  // requesters plus ALU side
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_z, alu_cout,
    input  req0_ready, rsp0_valid, rsp0_z, rsp0_carry,
    input  req1_ready, rsp1_valid, rsp1_z, rsp1_carry,
    input  busy, alu_a, alu_b, alu_c, alu_cin
  );
endinterface
`default_nettype wire

// File: rtl/alu_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_sched                                              |
// | Description : Round-robin scheduler sharing one combinational ALU    |
// |               between two requesters, one op in flight, private      |
// |               carry flag per requester.                              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module alu_sched #(
  parameter int WIDTH = 16
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  alu_sched_if.slave     bus_io
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXEC = 1'b1;

  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_ADC  = 4'b0101;
  localparam logic [3:0] OP_CLRC = 4'b1011;
  localparam logic [3:0] OP_SETC = 4'b1100;

  logic [0:0]       state_q, state_d;
  logic             rr_q;        // last winner; the other side wins a tie
  logic             owner_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry0_q, carry1_q;
  logic             rsp0_valid_q, rsp1_valid_q;
  logic [WIDTH-1:0] rsp0_z_q, rsp1_z_q;

  logic             w_grant0, w_grant1, w_accept;
  logic             w_cin, w_carry_d;
  logic [WIDTH-1:0] w_result;

  assign w_grant0 = bus_io.req0_valid & (~bus_io.req1_valid | rr_q);
  assign w_grant1 = bus_io.req1_valid & (~bus_io.req0_valid | ~rr_q);
  assign w_accept = (state_q == S_IDLE) & (w_grant0 | w_grant1);

  // Carry flag of the in-flight owner, fed to the ALU and the fix-up below
  assign w_cin = owner_q ? carry1_q : carry0_q;

  // ALU Z is undefined for the flag-only ops, so those return zero
  assign w_result = ((op_q == OP_CLRC) || (op_q == OP_SETC)) ? '0 : bus_io.alu_z;

  // New carry flag for the owner; the ALU's cout for ADC ignores carryIn,
  // and the only missed carry is a+b == all-ones with cin=1 (Z wraps to 0)
  always_comb begin
    w_carry_d = w_cin;
    case (op_q)
      OP_ADD:  w_carry_d = bus_io.alu_cout;
      OP_ADC:  w_carry_d = bus_io.alu_cout | (w_cin & (bus_io.alu_z == '0));
      OP_CLRC: w_carry_d = 1'b0;
      OP_SETC: w_carry_d = 1'b1;
      default: w_carry_d = w_cin;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: accept in IDLE moves to EXEC, EXEC always lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: handshake in IDLE, ALU operands only while executing
  always_comb begin
    bus_io.req0_ready = 1'b0;
    bus_io.req1_ready = 1'b0;
    bus_io.busy       = 1'b0;
    bus_io.alu_a      = '0;
    bus_io.alu_b      = '0;
    bus_io.alu_c      = 4'b0000;
    bus_io.alu_cin    = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus_io.req0_ready = rst_n & w_grant0;
        bus_io.req1_ready = rst_n & w_grant1;
      end
      S_EXEC: begin
        bus_io.busy    = 1'b1;
        bus_io.alu_a   = a_q;
        bus_io.alu_b   = b_q;
        bus_io.alu_c   = op_q;
        bus_io.alu_cin = w_cin;
      end
      default: ;
    endcase
  end

  // Datapath: latch the accepted op, then deliver result and carry for its owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q         <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= 4'b0000;
      a_q          <= '0;
      b_q          <= '0;
      carry0_q     <= 1'b0;
      carry1_q     <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_z_q     <= '0;
      rsp1_z_q     <= '0;
    end else begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      if (w_accept) begin
        owner_q <= w_grant1;
        rr_q    <= w_grant1;
        op_q    <= w_grant1 ? bus_io.req1_op : bus_io.req0_op;
        a_q     <= w_grant1 ? bus_io.req1_a  : bus_io.req0_a;
        b_q     <= w_grant1 ? bus_io.req1_b  : bus_io.req0_b;
      end
      if (state_q == S_EXEC) begin
        if (owner_q) begin
          rsp1_valid_q <= 1'b1;
          rsp1_z_q     <= w_result;
          carry1_q     <= w_carry_d;
        end else begin
          rsp0_valid_q <= 1'b1;
          rsp0_z_q     <= w_result;
          carry0_q     <= w_carry_d;
        end
      end
    end
  end

  assign bus_io.rsp0_valid = rsp0_valid_q;
  assign bus_io.rsp1_valid = rsp1_valid_q;
  assign bus_io.rsp0_z     = rsp0_z_q;
  assign bus_io.rsp1_z     = rsp1_z_q;
  assign bus_io.rsp0_carry = carry0_q;
  assign bus_io.rsp1_carry = carry1_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_alu_sched                                           |
// | Description : Self-checking bench for alu_sched with a behavioural   |
// |               ALU and a cycle-level reference model.                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_alu_sched;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_sched_if #(.WIDTH(W)) bus ();
  alu_sched #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus_io(bus));

  always #5 clk = ~clk;

  // External ALU: ADC's cout deliberately covers only a+b (carryIn omitted)
  function automatic logic [W:0] alu_f(input logic [3:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic cin);
    logic [W:0] s;
    case (op)
      4'b0000: s = {1'b0, a & b};
      4'b0001: s = {1'b0, a | b};
      4'b0010: s = {1'b0, a ^ b};
      4'b0011: s = {1'b0, ~a};
      4'b0100: s = {1'b0, a} + {1'b0, b};
      4'b0101: begin
        s = {1'b0, a} + {1'b0, b};
        s[W-1:0] = a + b + {{(W-1){1'b0}}, cin};
      end
      4'b0110: s = {1'b0, a - b};
      4'b0111: s = {1'b0, a << 1};
      4'b1000: s = {1'b0, a >> 1};
      4'b1001: s = {1'b0, b};
      4'b1010: s = {1'b0, a};
      4'b1011: s = {1'b1, 16'hDEAD};
      4'b1100: s = {1'b0, 16'hBEEF};
      4'b1101: s = {1'b0, ~(a & b)};
      4'b1110: s = {1'b0, a + 16'd1};
      default: s = {1'b0, ~b};
    endcase
    return s;
  endfunction

  always_comb {bus.alu_cout, bus.alu_z} = alu_f(bus.alu_c, bus.alu_a, bus.alu_b, bus.alu_cin);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  logic          m_exec = 1'b0;
  logic          m_last = 1'b1;
  logic [1:0]    m_c    = 2'b00;
  logic          m_own;
  logic [3:0]    m_op;
  logic [W-1:0]  m_a, m_b, m_z;
  logic          m_newc;
  logic          m_rsp = 1'b0;
  logic          m_rsp_own;
  logic [W-1:0]  m_rsp_z;
  logic [1:0]    acc = 2'b00;

  // Expected result/carry from plain arithmetic on the full-width sum
  task automatic model_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin);
    logic [W:0] r;
    int unsigned s;
    r = alu_f(op, a, b, cin);
    m_z = (op == 4'b1011 || op == 4'b1100) ? '0 : r[W-1:0];
    case (op)
      4'b0100: begin s = int'(a) + int'(b);            m_newc = s[W]; end
      4'b0101: begin s = int'(a) + int'(b) + int'(cin); m_newc = s[W]; end
      4'b1011: m_newc = 1'b0;
      4'b1100: m_newc = 1'b1;
      default: m_newc = cin;
    endcase
  endtask

  task automatic model_step();
    logic g0, g1;
    acc = 2'b00;
    if (!rst_n) begin
      check("rst_ready0", bus.req0_ready, 0);
      check("rst_ready1", bus.req1_ready, 0);
      check("rst_rspv",   {bus.rsp1_valid, bus.rsp0_valid}, 0);
      check("rst_busy",   bus.busy, 0);
      check("rst_carry",  {bus.rsp1_carry, bus.rsp0_carry}, 0);
      check("rst_alu",    {bus.alu_a, bus.alu_b, bus.alu_c}, 0);
      m_exec = 0; m_last = 1; m_c = 2'b00; m_rsp = 0;
      return;
    end
    check("rsp0_valid", bus.rsp0_valid, m_rsp && !m_rsp_own);
    check("rsp1_valid", bus.rsp1_valid, m_rsp && m_rsp_own);
    if (m_rsp) check("rsp_z", m_rsp_own ? bus.rsp1_z : bus.rsp0_z, m_rsp_z);
    check("carry0", bus.rsp0_carry, m_c[0]);
    check("carry1", bus.rsp1_carry, m_c[1]);
    check("busy", bus.busy, m_exec);
    if (m_exec) begin
      check("exec_ready", {bus.req1_ready, bus.req0_ready}, 0);
      check("exec_alu", {bus.alu_a, bus.alu_b, bus.alu_c}, {m_a, m_b, m_op});
      check("exec_cin", bus.alu_cin, m_c[m_own]);
      m_c[m_own] = m_newc;
      m_rsp = 1; m_rsp_own = m_own; m_rsp_z = m_z;
      m_exec = 0;
    end else begin
      g0 = bus.req0_valid && (!bus.req1_valid || m_last == 1'b1);
      g1 = bus.req1_valid && (!bus.req0_valid || m_last == 1'b0);
      check("ready0", bus.req0_ready, g0);
      check("ready1", bus.req1_ready, g1);
      check("idle_alu", {bus.alu_a, bus.alu_b, bus.alu_c, bus.alu_cin}, 0);
      m_rsp = 0;
      if (g0 || g1) begin
        m_own = g1;
        m_op  = g1 ? bus.req1_op : bus.req0_op;
        m_a   = g1 ? bus.req1_a  : bus.req0_a;
        m_b   = g1 ? bus.req1_b  : bus.req0_b;
        model_op(m_op, m_a, m_b, m_c[m_own]);
        m_last = m_own;
        m_exec = 1;
        acc[m_own] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    if (r == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  // Present one op and hold it until accepted (bounded)
  task automatic issue(input int r, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    bit done = 0;
    set_req(r, 1'b1, op, a, b);
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      done = acc[r];
    end
    if (!done) check("issue_timeout", 0, 1);
    set_req(r, 1'b0, op, a, b);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 4))
      0: return 16'hFFFF;
      1: return 16'hFFFE;
      2: return 16'h0001;
      3: return 16'h0000;
      default: return W'($urandom);
    endcase
  endfunction

  int winners[$];

  initial begin
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    tick(); tick();
    rst_n = 1'b1;

    // Both requesters valid every cycle with fresh ops: grants alternate 0,1,0,1
    set_req(0, 1, 4'b0010, 16'h00F0, 16'h0F0F);
    set_req(1, 1, 4'b0110, 16'h1234, 16'h0034);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (acc[0]) begin winners.push_back(0); set_req(0, 1, 4'(i), rnd_operand(), rnd_operand()); end
      if (acc[1]) begin winners.push_back(1); set_req(1, 1, 4'(i + 7), rnd_operand(), rnd_operand()); end
    end
    check("alt_count", winners.size(), 4);
    foreach (winners[k]) check("alt_order", winners[k], k % 2);
    // drain whichever requester is still pending
    while (bus.req0_valid || bus.req1_valid) begin
      tick();
      if (acc[0]) bus.req0_valid = 0;
      if (acc[1]) bus.req1_valid = 0;
    end
    tick(); tick();

    // ADD overflow then ADC with carry fix-up on requester 0
    issue(0, 4'b0100, 16'hFFFF, 16'h0001);
    tick();
    check("add_rspv", bus.rsp0_valid, 1);
    check("add_z", bus.rsp0_z, 16'h0000);
    check("add_carry", bus.rsp0_carry, 1);
    issue(0, 4'b0101, 16'hFFFE, 16'h0001);
    check("adc_cin", bus.alu_cin, 1);
    tick();
    check("adc_z", bus.rsp0_z, 16'h0000);
    check("adc_carry", bus.rsp0_carry, 1);

    // Requester 1: set carry, then ADC uses it; requester 0 flag untouched
    issue(1, 4'b1100, 16'h5555, 16'hAAAA);
    tick();
    check("setc_z", bus.rsp1_z, 16'h0000);
    check("setc_carry", bus.rsp1_carry, 1);
    issue(1, 4'b0101, 16'h0003, 16'h0004);
    tick();
    check("adc1_z", bus.rsp1_z, 16'h0008);
    check("carry0_kept", bus.rsp0_carry, 1);
    tick();

    // Reset during EXEC: no response, flags cleared, req0 wins next
    issue(1, 4'b0100, 16'hFFFF, 16'hFFFF);
    set_req(0, 1, 4'b0001, 16'h00FF, 16'hFF00);
    set_req(1, 1, 4'b0010, 16'h0F0F, 16'hFFFF);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_grant0", acc, 2'b01);

    // Randomized traffic with valid held until accepted
    for (int i = 0; i < 400; i++) begin
      if (acc[0]) bus.req0_valid = 0;
      if (acc[1]) bus.req1_valid = 0;
      if (!bus.req0_valid && $urandom_range(0, 2) != 0)
        set_req(0, 1, 4'($urandom), rnd_operand(), rnd_operand());
      if (!bus.req1_valid && $urandom_range(0, 2) != 0)
        set_req(1, 1, 4'($urandom), rnd_operand(), rnd_operand());
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
